// File: rtl/booth4_serial_acc_if.sv
// rtl/booth4_serial_acc_if.sv - handshake and operand bundle for the serial Booth accumulator
interface booth4_serial_acc_if #(
  parameter int WIDTH = 8
);
  logic                 start;
  logic [WIDTH-1:0]     y;
  logic [WIDTH-1:0]     x_pos;
  logic [WIDTH-1:0]     x_neg;
  logic [WIDTH:0]       x_dbl;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, y, x_pos, x_neg, x_dbl,
    input  busy, done, product
  );

  modport slave (
    input  start, y, x_pos, x_neg, x_dbl,
    output busy, done, product
  );
endinterface

// File: rtl/booth4_serial_acc.sv
// rtl/booth4_serial_acc.sv - radix-4 Booth serial multiply-accumulate over registered x candidates
module booth4_serial_acc #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  booth4_serial_acc_if.slave bus
);
  localparam int AW   = 2*WIDTH + 2;
  localparam int HALF = WIDTH/2;
  localparam int IW   = (HALF > 1) ? $clog2(HALF) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t              state;
  state_t              state_next;
  logic                busy;
  logic                done;
  logic                last;
  logic [WIDTH:0]      ybits;     // multiplier with the implicit y[-1]=0 appended at bit 0
  logic [WIDTH-1:0]    xp;
  logic [WIDTH-1:0]    xn;
  logic [WIDTH:0]      xd;
  logic [AW-1:0]       acc;
  logic [AW-1:0]       term;
  logic [AW-1:0]       acc_sum;
  logic [IW-1:0]       idx;
  logic [2*WIDTH-1:0]  prod;

  assign last        = (idx == IW'(HALF-1));
  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.product = prod;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and status outputs; start is only honoured in IDLE
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (bus.start) state_next = LOAD;
      LOAD: begin
        busy       = 1'b1;
        state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Booth digit select from the low triplet; negatives use ~x plus a carry-in of one
  always_comb begin
    term = '0;
    case (ybits[2:0])
      3'b001, 3'b010: term = {{(AW-WIDTH){xp[WIDTH-1]}}, xp};
      3'b011:         term = {{(AW-WIDTH-1){xd[WIDTH]}}, xd};
      3'b100:         term = {{(AW-WIDTH-1){xn[WIDTH-1]}}, xn, 1'b1} + AW'(1);
      3'b101, 3'b110: term = {{(AW-WIDTH){xn[WIDTH-1]}}, xn} + AW'(1);
      default:        term = '0;
    endcase
    acc_sum = acc + (term << {idx, 1'b0});
  end

  // Operand capture, accumulation and result register; product is written on the
  // final digit edge so it is already valid in the cycle done is high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ybits <= '0;
      xp    <= '0;
      xn    <= '0;
      xd    <= '0;
      acc   <= '0;
      idx   <= '0;
      prod  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) ybits <= {bus.y, 1'b0};
        end
        LOAD: begin
          xp  <= bus.x_pos;
          xn  <= bus.x_neg;
          xd  <= bus.x_dbl;
          acc <= '0;
          idx <= '0;
        end
        RUN: begin
          acc   <= acc_sum;
          idx   <= idx + IW'(1);
          ybits <= {{2{ybits[WIDTH]}}, ybits[WIDTH:2]};
          if (last) prod <= acc_sum[2*WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end
endmodule
